uut_run_controller: RTL and testbench

//  Generic run controller between the SD-card autotest engine and any hash/MAC UUT.
//  Per test vector it:
//   - latches the vector and holds the UUT in reset for a programmable number of cycles;
//   - releases the UUT and counts cycles until end/err/timeout/abort;
//   - captures the digest and reports status plus latency.

---
 rtl/uut_run_controller_pkg.sv | 18 +
 rtl/uut_run_controller_if.sv | 36 +++
 rtl/uut_run_controller_counter.sv | 25 ++
 rtl/uut_run_controller.sv | 120 ++++++++++++
 tb/tb_uut_run_controller.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uut_run_controller_pkg.sv
// rtl/uut_run_controller_pkg.sv - shared state and status encodings for the UUT run controller
package uut_run_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_UUT_ERR = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_ABORT   = 2'd3
    } status_t;

endpackage

// File: rtl/uut_run_controller_if.sv
// rtl/uut_run_controller_if.sv - host and UUT signal bundle of the run controller
interface uut_run_controller_if #(
    parameter int IN_W  = 128,
    parameter int OUT_W = 88,
    parameter int CNT_W = 24
);
    import uut_run_pkg::*;

    logic             start_i;
    logic [IN_W-1:0]  vector_i;
    logic [CNT_W-1:0] timeout_i;
    logic             abort_i;
    logic             busy_o;
    logic             done_o;
    logic [OUT_W-1:0] result_o;
    status_t          status_o;
    logic [CNT_W-1:0] cycles_o;

    logic             uut_rst_o;
    logic [IN_W-1:0]  uut_in_o;
    logic             uut_end_i;
    logic             uut_err_i;
    logic [OUT_W-1:0] uut_out_i;

    // master = autotest engine plus UUT model, slave = the controller
    modport master (
        output start_i, vector_i, timeout_i, abort_i, uut_end_i, uut_err_i, uut_out_i,
        input  busy_o, done_o, result_o, status_o, cycles_o, uut_rst_o, uut_in_o
    );

    modport slave (
        input  start_i, vector_i, timeout_i, abort_i, uut_end_i, uut_err_i, uut_out_i,
        output busy_o, done_o, result_o, status_o, cycles_o, uut_rst_o, uut_in_o
    );

endinterface

// File: rtl/uut_run_controller_counter.sv
// rtl/uut_run_controller_counter.sv - saturating up-counter with synchronous clear
module sat_cycle_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         sat
);

    assign sat = &q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && !sat) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/uut_run_controller.sv
// rtl/uut_run_controller.sv - per-vector UUT reset, run timing and result capture
module uut_run_controller
    import uut_run_pkg::*;
#(
    parameter int IN_W        = 128,
    parameter int OUT_W       = 88,
    parameter int RST_CYCLES  = 4,
    parameter int CNT_W       = 24,
    parameter int UUT_RST_POL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uut_run_controller_if.slave  bus
);

    localparam logic RST_ON = (UUT_RST_POL != 0);
    localparam int   HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] timeout_q;
    logic [HOLD_W-1:0] hold_q;
    logic             hold_sat;
    logic [CNT_W-1:0] run_q;
    logic             run_sat;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             hold_done;
    logic             tmo_hit;

    assign accept    = (state == IDLE) && bus.start_i;
    assign hold_done = (hold_q == HOLD_LAST) || hold_sat;
    // count including the current RUN cycle, so a terminating cycle is always counted
    assign cnt_next  = run_sat ? run_q : run_q + 1'b1;
    assign tmo_hit   = (timeout_q != '0) && (cnt_next == timeout_q);

    sat_cycle_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr   (accept),
        .en    (state == RESET),
        .q     (hold_q),
        .sat   (hold_sat)
    );

    sat_cycle_counter #(.W(CNT_W)) u_run_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr   (accept),
        .en    (state == RUN),
        .q     (run_q),
        .sat   (run_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            timeout_q     <= '0;
            bus.busy_o    <= 1'b0;
            bus.done_o    <= 1'b0;
            bus.result_o  <= {OUT_W{1'b0}};
            bus.status_o  <= ST_OK;
            bus.cycles_o  <= '0;
            bus.uut_rst_o <= RST_ON;
            bus.uut_in_o  <= {IN_W{1'b0}};
        end else begin
            bus.done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        bus.uut_in_o <= bus.vector_i;
                        timeout_q    <= bus.timeout_i;
                        bus.busy_o   <= 1'b1;
                        state        <= RESET;
                    end
                end
                RESET: begin
                    // UUT end/err are stale here and deliberately not looked at
                    if (bus.abort_i) begin
                        state        <= DONE;
                        bus.done_o   <= 1'b1;
                        bus.status_o <= ST_ABORT;
                        bus.result_o <= {OUT_W{1'b0}};
                        bus.cycles_o <= run_q;
                    end else if (hold_done) begin
                        state         <= RUN;
                        bus.uut_rst_o <= ~RST_ON;
                    end
                end
                RUN: begin
                    if (bus.abort_i || bus.uut_err_i || bus.uut_end_i || tmo_hit) begin
                        state         <= DONE;
                        bus.done_o    <= 1'b1;
                        bus.uut_rst_o <= RST_ON;
                        bus.cycles_o  <= cnt_next;
                        if (bus.abort_i) begin
                            bus.status_o <= ST_ABORT;
                            bus.result_o <= {OUT_W{1'b0}};
                        end else if (bus.uut_err_i) begin
                            bus.status_o <= ST_UUT_ERR;
                            bus.result_o <= bus.uut_out_i;
                        end else if (bus.uut_end_i) begin
                            bus.status_o <= ST_OK;
                            bus.result_o <= bus.uut_out_i;
                        end else begin
                            bus.status_o <= ST_TIMEOUT;
                            bus.result_o <= {OUT_W{1'b0}};
                        end
                    end
                end
                DONE: begin
                    bus.busy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uut_run_controller.sv
// tb/tb_uut_run_controller.sv - directed self-checking bench for uut_run_controller
module tb_uut_run_controller;
    import uut_run_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    uut_run_controller_if #(.IN_W(128), .OUT_W(88), .CNT_W(24)) bus_a ();
    uut_run_controller_if #(.IN_W(128), .OUT_W(88), .CNT_W(4))  bus_b ();

    uut_run_controller #(.IN_W(128), .OUT_W(88), .RST_CYCLES(4), .CNT_W(24), .UUT_RST_POL(1)) dut_a (
        .clk (clk), .rst (rst_n), .bus (bus_a.slave)
    );

    uut_run_controller #(.IN_W(128), .OUT_W(88), .RST_CYCLES(4), .CNT_W(4), .UUT_RST_POL(0)) dut_b (
        .clk (clk), .rst (rst_n), .bus (bus_b.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus_a.busy_o !== 1'b0 || bus_a.done_o !== 1'b0 || bus_a.uut_rst_o !== 1'b1 ||
                bus_a.result_o !== 88'd0 || bus_a.status_o !== ST_OK || bus_a.cycles_o !== 24'd0 ||
                bus_a.uut_in_o !== 128'd0)
                $display("FAIL reset_a cycle %0d: busy=%b done=%b uut_rst=%b result=%h status=%0d cycles=%0d want 0 0 1 0 0 0",
                         i, bus_a.busy_o, bus_a.done_o, bus_a.uut_rst_o, bus_a.result_o, bus_a.status_o, bus_a.cycles_o);
            else passes++;
        end
        checks++;
        if (bus_b.uut_rst_o !== 1'b0 || bus_b.busy_o !== 1'b0)
            $display("FAIL reset_b: uut_rst=%b busy=%b want 0 0", bus_b.uut_rst_o, bus_b.busy_o);
        else passes++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        int n;
        bus_a.start_i   = 1'b1;
        bus_a.vector_i  = {16{8'hA5}};
        bus_a.timeout_i = 24'd0;
        tick();
        bus_a.start_i  = 1'b0;
        bus_a.vector_i = 128'd0;
        checks++;
        if (bus_a.busy_o !== 1'b1 || bus_a.uut_in_o !== {16{8'hA5}})
            $display("FAIL normal_accept: busy=%b uut_in=%h want 1 a5..a5", bus_a.busy_o, bus_a.uut_in_o);
        else passes++;
        n = 0;
        while (bus_a.uut_rst_o === 1'b1 && n < 20) begin n++; tick(); end
        checks++;
        if (n !== 4) $display("FAIL normal_rst_len: got %0d want 4", n);
        else passes++;
        repeat (44) tick();
        bus_a.uut_end_i = 1'b1;
        bus_a.uut_out_i = 88'h1234;
        tick();
        bus_a.uut_end_i = 1'b0;
        bus_a.uut_out_i = 88'd0;
        checks++;
        if (bus_a.done_o !== 1'b1 || bus_a.busy_o !== 1'b1 || bus_a.status_o !== ST_OK ||
            bus_a.result_o !== 88'h1234 || bus_a.cycles_o !== 24'd45 || bus_a.uut_rst_o !== 1'b1)
            $display("FAIL normal_done: done=%b busy=%b status=%0d result=%h cycles=%0d uut_rst=%b want 1 1 0 1234 45 1",
                     bus_a.done_o, bus_a.busy_o, bus_a.status_o, bus_a.result_o, bus_a.cycles_o, bus_a.uut_rst_o);
        else passes++;
        tick();
        checks++;
        if (bus_a.done_o !== 1'b0 || bus_a.busy_o !== 1'b0 || bus_a.result_o !== 88'h1234)
            $display("FAIL normal_idle: done=%b busy=%b result=%h want 0 0 1234", bus_a.done_o, bus_a.busy_o, bus_a.result_o);
        else passes++;
    endtask

    task automatic test_timeout();
        int n;
        bus_a.start_i   = 1'b1;
        bus_a.vector_i  = 128'h1;
        bus_a.timeout_i = 24'd100;
        tick();
        bus_a.start_i   = 1'b0;
        bus_a.timeout_i = 24'd0;
        n = 0;
        while (bus_a.uut_rst_o === 1'b1 && n < 20) begin n++; tick(); end
        checks++;
        if (bus_a.result_o !== 88'h1234 || bus_a.cycles_o !== 24'd45)
            $display("FAIL timeout_hold_prev: result=%h cycles=%0d want 1234 45", bus_a.result_o, bus_a.cycles_o);
        else passes++;
        n = 0;
        while (bus_a.done_o !== 1'b1 && n < 300) begin n++; tick(); end
        checks++;
        if (n !== 100) $display("FAIL timeout_cycle: done after %0d run cycles want 100", n);
        else passes++;
        checks++;
        if (bus_a.status_o !== ST_TIMEOUT || bus_a.result_o !== 88'd0 || bus_a.cycles_o !== 24'd100)
            $display("FAIL timeout_status: status=%0d result=%h cycles=%0d want 2 0 100",
                     bus_a.status_o, bus_a.result_o, bus_a.cycles_o);
        else passes++;
        tick();
    endtask

    task automatic test_tie_stale();
        int n;
        bus_a.start_i   = 1'b1;
        bus_a.vector_i  = 128'h2;
        bus_a.timeout_i = 24'd0;
        tick();
        bus_a.start_i   = 1'b0;
        bus_a.uut_end_i = 1'b1;
        tick();
        tick();
        checks++;
        if (bus_a.done_o !== 1'b0 || bus_a.uut_rst_o !== 1'b1)
            $display("FAIL stale_end: done=%b uut_rst=%b want 0 1", bus_a.done_o, bus_a.uut_rst_o);
        else passes++;
        bus_a.uut_end_i = 1'b0;
        n = 0;
        while (bus_a.uut_rst_o === 1'b1 && n < 20) begin n++; tick(); end
        tick();
        tick();
        bus_a.uut_end_i = 1'b1;
        bus_a.uut_err_i = 1'b1;
        bus_a.uut_out_i = 88'hBEEF;
        tick();
        bus_a.uut_end_i = 1'b0;
        bus_a.uut_err_i = 1'b0;
        bus_a.uut_out_i = 88'd0;
        checks++;
        if (bus_a.done_o !== 1'b1 || bus_a.status_o !== ST_UUT_ERR || bus_a.result_o !== 88'hBEEF ||
            bus_a.cycles_o !== 24'd3)
            $display("FAIL tie_err: done=%b status=%0d result=%h cycles=%0d want 1 1 beef 3",
                     bus_a.done_o, bus_a.status_o, bus_a.result_o, bus_a.cycles_o);
        else passes++;
        tick();
    endtask

    task automatic test_abort();
        int n;
        bus_a.abort_i = 1'b1;
        tick();
        bus_a.abort_i = 1'b0;
        checks++;
        if (bus_a.busy_o !== 1'b0 || bus_a.done_o !== 1'b0)
            $display("FAIL abort_idle: busy=%b done=%b want 0 0", bus_a.busy_o, bus_a.done_o);
        else passes++;
        bus_a.start_i  = 1'b1;
        bus_a.vector_i = {4{32'hDEADBEEF}};
        tick();
        bus_a.start_i = 1'b0;
        n = 0;
        while (bus_a.uut_rst_o === 1'b1 && n < 20) begin n++; tick(); end
        repeat (6) tick();
        bus_a.abort_i  = 1'b1;
        bus_a.start_i  = 1'b1;
        bus_a.vector_i = {4{32'hCAFEF00D}};
        tick();
        bus_a.abort_i = 1'b0;
        bus_a.start_i = 1'b0;
        checks++;
        if (bus_a.done_o !== 1'b1 || bus_a.status_o !== ST_ABORT || bus_a.cycles_o !== 24'd7 ||
            bus_a.result_o !== 88'd0 || bus_a.uut_in_o !== {4{32'hDEADBEEF}})
            $display("FAIL abort_run: done=%b status=%0d cycles=%0d result=%h uut_in=%h want 1 3 7 0 deadbeef..",
                     bus_a.done_o, bus_a.status_o, bus_a.cycles_o, bus_a.result_o, bus_a.uut_in_o);
        else passes++;
        tick();
        tick();
        checks++;
        if (bus_a.busy_o !== 1'b0 || bus_a.uut_in_o !== {4{32'hDEADBEEF}})
            $display("FAIL abort_no_queue: busy=%b uut_in=%h want 0 deadbeef..", bus_a.busy_o, bus_a.uut_in_o);
        else passes++;
        bus_a.start_i = 1'b1;
        tick();
        bus_a.start_i = 1'b0;
        checks++;
        if (bus_a.busy_o !== 1'b1 || bus_a.uut_in_o !== {4{32'hCAFEF00D}})
            $display("FAIL abort_next_start: busy=%b uut_in=%h want 1 cafef00d..", bus_a.busy_o, bus_a.uut_in_o);
        else passes++;
        bus_a.abort_i = 1'b1;
        tick();
        bus_a.abort_i = 1'b0;
        checks++;
        if (bus_a.done_o !== 1'b1 || bus_a.status_o !== ST_ABORT || bus_a.cycles_o !== 24'd0 ||
            bus_a.uut_rst_o !== 1'b1)
            $display("FAIL abort_reset: done=%b status=%0d cycles=%0d uut_rst=%b want 1 3 0 1",
                     bus_a.done_o, bus_a.status_o, bus_a.cycles_o, bus_a.uut_rst_o);
        else passes++;
        tick();
    endtask

    task automatic test_sat_polarity();
        int n;
        bus_b.start_i   = 1'b1;
        bus_b.vector_i  = 128'h55;
        bus_b.timeout_i = 4'd0;
        tick();
        bus_b.start_i = 1'b0;
        n = 0;
        while (bus_b.uut_rst_o === 1'b0 && n < 20) begin n++; tick(); end
        checks++;
        if (n !== 4 || bus_b.uut_rst_o !== 1'b1)
            $display("FAIL pol_rst_low: low for %0d uut_rst=%b want 4 1", n, bus_b.uut_rst_o);
        else passes++;
        repeat (19) tick();
        bus_b.uut_end_i = 1'b1;
        bus_b.uut_out_i = 88'h77;
        tick();
        bus_b.uut_end_i = 1'b0;
        checks++;
        if (bus_b.done_o !== 1'b1 || bus_b.cycles_o !== 4'd15 || bus_b.status_o !== ST_OK ||
            bus_b.result_o !== 88'h77 || bus_b.uut_rst_o !== 1'b0)
            $display("FAIL sat_done: done=%b cycles=%0d status=%0d result=%h uut_rst=%b want 1 15 0 77 0",
                     bus_b.done_o, bus_b.cycles_o, bus_b.status_o, bus_b.result_o, bus_b.uut_rst_o);
        else passes++;
        tick();
    endtask

    task automatic test_async_reset();
        int n;
        bus_a.start_i  = 1'b1;
        bus_a.vector_i = 128'h99;
        tick();
        bus_a.start_i = 1'b0;
        n = 0;
        while (bus_a.uut_rst_o === 1'b1 && n < 20) begin n++; tick(); end
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_a.busy_o !== 1'b0 || bus_a.uut_rst_o !== 1'b1 || bus_a.uut_in_o !== 128'd0 ||
            bus_a.status_o !== ST_OK || bus_a.result_o !== 88'd0 || bus_b.result_o !== 88'd0)
            $display("FAIL async_reset: busy=%b uut_rst=%b uut_in=%h status=%0d want 0 1 0 0",
                     bus_a.busy_o, bus_a.uut_rst_o, bus_a.uut_in_o, bus_a.status_o);
        else passes++;
        bus_a.uut_end_i = 1'b1;
        tick();
        tick();
        checks++;
        if (bus_a.done_o !== 1'b0 || bus_a.busy_o !== 1'b0)
            $display("FAIL async_no_done: done=%b busy=%b want 0 0", bus_a.done_o, bus_a.busy_o);
        else passes++;
        bus_a.uut_end_i = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bus_a.start_i = 1'b0; bus_a.vector_i = '0; bus_a.timeout_i = '0; bus_a.abort_i = 1'b0;
        bus_a.uut_end_i = 1'b0; bus_a.uut_err_i = 1'b0; bus_a.uut_out_i = '0;
        bus_b.start_i = 1'b0; bus_b.vector_i = '0; bus_b.timeout_i = '0; bus_b.abort_i = 1'b0;
        bus_b.uut_end_i = 1'b0; bus_b.uut_err_i = 1'b0; bus_b.uut_out_i = '0;
        test_reset();
        test_normal();
        test_timeout();
        test_tie_stale();
        test_abort();
        test_sat_polarity();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
